// File: rtl/uart_text_console.sv
// uart_text_console
//
// Byte-stream terminal engine that sits between a UART receiver and a
// glyph-to-VRAM writer. Incoming bytes are queued in a small FIFO so that
// bursts survive while a glyph is being drawn. The engine interprets CR, LF,
// BS, TAB, FF (clear screen) and an ESC-prefixed colour select, tracks the
// cursor over a TEXT_COLS x TEXT_ROWS grid, and issues one glyph write per
// printable character.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   rx_received       UART "byte received" level; rising edge = rx_data valid
//   rx_data[7:0]      received byte
//   char_busy         glyph writer busy; a write request waits while high
//   char_done         glyph writer 1-cycle completion pulse
//   char_write        1-cycle glyph write request
//   char_ascii/x/y/color  glyph descriptor, stable from char_write to char_done
//   cursor_x/y        current cursor position
//   fifo_overflow     sticky: a byte was dropped on a full FIFO
//   busy              FIFO non-empty or engine not idle
//
// State table
//   S_IDLE      | waiting for a byte; pops the FIFO when non-empty
//   S_DECODE    | interprets the popped byte
//   S_ISSUE     | waits for !char_busy, then pulses char_write
//   S_WAIT      | waits for char_done of a printable or backspace glyph
//   S_CLR_ISSUE | as S_ISSUE, for the current clear-screen cell
//   S_CLR_WAIT  | waits for char_done, steps to the next cell row-major

module uart_text_console #(
    parameter int          TEXT_COLS     = 106,
    parameter int          TEXT_ROWS     = 30,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          TAB_WIDTH     = 8,
    parameter logic [11:0] DEFAULT_COLOR = 12'hFFF,
    localparam int         X_W           = $clog2(TEXT_COLS),
    localparam int         Y_W           = $clog2(TEXT_ROWS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_received,
    input  logic [7:0]     rx_data,
    input  logic           char_busy,
    input  logic           char_done,
    output logic           char_write,
    output logic [6:0]     char_ascii,
    output logic [X_W-1:0] char_x,
    output logic [Y_W-1:0] char_y,
    output logic [11:0]    char_color,
    output logic [X_W-1:0] cursor_x,
    output logic [Y_W-1:0] cursor_y,
    output logic           fifo_overflow,
    output logic           busy
);

    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [X_W-1:0] COL_MAX  = X_W'(TEXT_COLS - 1);
    localparam logic [Y_W-1:0] ROW_MAX  = Y_W'(TEXT_ROWS - 1);
    localparam logic [X_W:0]   TAB_MASK = (X_W + 1)'(TAB_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_CLR_ISSUE,
        S_CLR_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Input edge detector and FIFO
    // ------------------------------------------------------------------
    logic             rx_prev_q, rx_prev_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    always_comb begin : fifo_next
        rx_prev_d  = rx_received;
        push_req   = rx_received && !rx_prev_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok    = push_req && (!fifo_full || pop);
        overflow_d = overflow_q || (push_req && !push_ok);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Terminal FSM
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [7:0]     byte_q, byte_d;
    logic [X_W-1:0] cursor_x_q, cursor_x_d;
    logic [Y_W-1:0] cursor_y_q, cursor_y_d;
    logic           char_write_q, char_write_d;
    logic [6:0]     char_ascii_q, char_ascii_d;
    logic [X_W-1:0] char_x_q, char_x_d;
    logic [Y_W-1:0] char_y_q, char_y_d;
    logic [11:0]    char_color_q, char_color_d;
    logic [11:0]    color_q, color_d;
    logic           esc_q, esc_d;
    logic           advance_q, advance_d;

    logic           is_print;
    logic [Y_W-1:0] row_next;
    logic [X_W:0]   tab_x;
    logic           clr_last;

    assign is_print = (byte_q >= 8'h20) && (byte_q <= 8'h7E);
    assign row_next = (cursor_y_q == ROW_MAX) ? '0 : cursor_y_q + 1'b1;
    // One extra bit so a tab past the last stop is seen rather than wrapped.
    assign tab_x    = ({1'b0, cursor_x_q} | TAB_MASK) + 1'b1;
    assign clr_last = (char_x_q == COL_MAX) && (char_y_q == ROW_MAX);

    always_comb begin : fsm_next
        state_d      = state_q;
        byte_d       = byte_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        char_write_d = 1'b0;
        char_ascii_d = char_ascii_q;
        char_x_d     = char_x_q;
        char_y_d     = char_y_q;
        char_color_d = char_color_q;
        color_d      = color_q;
        esc_d        = esc_q;
        advance_d    = advance_q;
        pop          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    byte_d  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_IDLE;
                if (esc_q) begin
                    // Each low bit selects full or zero intensity on one channel.
                    color_d = {{4{byte_q[2]}}, {4{byte_q[1]}}, {4{byte_q[0]}}};
                    esc_d   = 1'b0;
                end else if (is_print) begin
                    char_ascii_d = byte_q[6:0];
                    char_x_d     = cursor_x_q;
                    char_y_d     = cursor_y_q;
                    char_color_d = color_q;
                    advance_d    = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    case (byte_q)
                        8'h0D: cursor_x_d = '0;
                        8'h0A: cursor_y_d = row_next;
                        8'h09: begin
                            if (tab_x > {1'b0, COL_MAX}) begin
                                cursor_x_d = '0;
                                cursor_y_d = row_next;
                            end else begin
                                cursor_x_d = tab_x[X_W-1:0];
                            end
                        end
                        8'h08: begin
                            // Backspace blanks the cell it moves onto; at the
                            // home position there is nowhere to move.
                            if (cursor_x_q != '0) begin
                                cursor_x_d   = cursor_x_q - 1'b1;
                                char_x_d     = cursor_x_q - 1'b1;
                                char_y_d     = cursor_y_q;
                                char_ascii_d = 7'h20;
                                char_color_d = color_q;
                                advance_d    = 1'b0;
                                state_d      = S_ISSUE;
                            end else if (cursor_y_q != '0) begin
                                cursor_x_d   = COL_MAX;
                                cursor_y_d   = cursor_y_q - 1'b1;
                                char_x_d     = COL_MAX;
                                char_y_d     = cursor_y_q - 1'b1;
                                char_ascii_d = 7'h20;
                                char_color_d = color_q;
                                advance_d    = 1'b0;
                                state_d      = S_ISSUE;
                            end
                        end
                        8'h0C: begin
                            char_ascii_d = 7'h20;
                            char_x_d     = '0;
                            char_y_d     = '0;
                            char_color_d = color_q;
                            state_d      = S_CLR_ISSUE;
                        end
                        8'h1B: esc_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            S_ISSUE: begin
                if (!char_busy) begin
                    char_write_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end

            S_WAIT: begin
                // A done coincident with our own request is not ours.
                if (char_done && !char_write_q) begin
                    state_d = S_IDLE;
                    if (advance_q) begin
                        if (cursor_x_q == COL_MAX) begin
                            cursor_x_d = '0;
                            cursor_y_d = row_next;
                        end else begin
                            cursor_x_d = cursor_x_q + 1'b1;
                        end
                    end
                end
            end

            S_CLR_ISSUE: begin
                if (!char_busy) begin
                    char_write_d = 1'b1;
                    state_d      = S_CLR_WAIT;
                end
            end

            S_CLR_WAIT: begin
                if (char_done && !char_write_q) begin
                    if (clr_last) begin
                        cursor_x_d = '0;
                        cursor_y_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        if (char_x_q == COL_MAX) begin
                            char_x_d = '0;
                            char_y_d = char_y_q + 1'b1;
                        end else begin
                            char_x_d = char_x_q + 1'b1;
                        end
                        state_d = S_CLR_ISSUE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            state_q      <= S_IDLE;
            byte_q       <= '0;
            cursor_x_q   <= '0;
            cursor_y_q   <= '0;
            char_write_q <= 1'b0;
            char_ascii_q <= '0;
            char_x_q     <= '0;
            char_y_q     <= '0;
            char_color_q <= DEFAULT_COLOR;
            color_q      <= DEFAULT_COLOR;
            esc_q        <= 1'b0;
            advance_q    <= 1'b0;
        end else begin
            rx_prev_q    <= rx_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            byte_q       <= byte_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            char_write_q <= char_write_d;
            char_ascii_q <= char_ascii_d;
            char_x_q     <= char_x_d;
            char_y_q     <= char_y_d;
            char_color_q <= char_color_d;
            color_q      <= color_d;
            esc_q        <= esc_d;
            advance_q    <= advance_d;
        end
    end

    assign char_write    = char_write_q;
    assign char_ascii    = char_ascii_q;
    assign char_x        = char_x_q;
    assign char_y        = char_y_q;
    assign char_color    = char_color_q;
    assign cursor_x      = cursor_x_q;
    assign cursor_y      = cursor_y_q;
    assign fifo_overflow = overflow_q;
    assign busy          = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_text_console.sv
// Testbench for uart_text_console: a full-size instance (106x30) checked
// against a behavioural terminal model, plus a 4x2 instance for clear-screen.

module tb_uart_text_console;

    localparam int COLS  = 106;
    localparam int ROWS  = 30;
    localparam int DEPTH = 16;
    localparam int TABW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rx_received;
    logic [7:0]  rx_data;
    logic        char_busy;
    logic        char_done;
    logic        char_write;
    logic [6:0]  char_ascii;
    logic [6:0]  char_x;
    logic [4:0]  char_y;
    logic [11:0] char_color;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        fifo_overflow;
    logic        busy;

    logic        s_rx_received;
    logic [7:0]  s_rx_data;
    logic        s_char_busy;
    logic        s_char_done;
    logic        s_char_write;
    logic [6:0]  s_char_ascii;
    logic [1:0]  s_char_x;
    logic [0:0]  s_char_y;
    logic [11:0] s_char_color;
    logic [1:0]  s_cursor_x;
    logic [0:0]  s_cursor_y;
    logic        s_fifo_overflow;
    logic        s_busy;

    logic resp_done;
    logic stray_done;
    bit   auto_done = 1'b1;
    assign char_done = resp_done | stray_done;

    uart_text_console #(
        .TEXT_COLS(COLS), .TEXT_ROWS(ROWS), .FIFO_DEPTH(DEPTH),
        .TAB_WIDTH(TABW), .DEFAULT_COLOR(12'hFFF)
    ) dut (
        .clk(clk), .rst(rst), .rx_received(rx_received), .rx_data(rx_data),
        .char_busy(char_busy), .char_done(char_done), .char_write(char_write),
        .char_ascii(char_ascii), .char_x(char_x), .char_y(char_y),
        .char_color(char_color), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .fifo_overflow(fifo_overflow), .busy(busy)
    );

    uart_text_console #(
        .TEXT_COLS(4), .TEXT_ROWS(2), .FIFO_DEPTH(4),
        .TAB_WIDTH(2), .DEFAULT_COLOR(12'hFFF)
    ) dut_small (
        .clk(clk), .rst(rst), .rx_received(s_rx_received), .rx_data(s_rx_data),
        .char_busy(s_char_busy), .char_done(s_char_done), .char_write(s_char_write),
        .char_ascii(s_char_ascii), .char_x(s_char_x), .char_y(s_char_y),
        .char_color(s_char_color), .cursor_x(s_cursor_x), .cursor_y(s_cursor_y),
        .fifo_overflow(s_fifo_overflow), .busy(s_busy)
    );

    int n_checks;
    int n_fail;

    // Recorded glyph writes: {ascii, x, y, color}
    logic [30:0] got_q[$];
    logic [30:0] exp_q[$];
    logic [21:0] s_got_q[$];

    // ---------------- glyph writer responders ----------------
    initial begin
        resp_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (char_write === 1'b1) begin
                got_q.push_back({char_ascii, char_x, char_y, char_color});
                if (auto_done) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    @(posedge clk); #1 resp_done = 1'b1;
                    @(posedge clk); #1 resp_done = 1'b0;
                end
            end
        end
    end

    initial begin
        s_char_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_char_write === 1'b1) begin
                s_got_q.push_back({s_char_ascii, s_char_x, s_char_y, s_char_color});
                @(posedge clk); #1 s_char_done = 1'b1;
                @(posedge clk); #1 s_char_done = 1'b0;
            end
        end
    end

    // ---------------- behavioural terminal model ----------------
    int          m_x, m_y;
    logic [11:0] m_col;
    bit          m_esc;

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_col = 12'hFFF; m_esc = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int nx;
        if (m_esc) begin
            m_col = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
            m_esc = 1'b0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({b[6:0], 7'(m_x), 5'(m_y), m_col});
            m_x = m_x + 1;
            if (m_x == COLS) begin
                m_x = 0;
                m_y = (m_y + 1) % ROWS;
            end
        end else begin
            case (b)
                8'h0D: m_x = 0;
                8'h0A: m_y = (m_y + 1) % ROWS;
                8'h09: begin
                    nx = (m_x / TABW + 1) * TABW;   // next tab stop strictly right
                    if (nx >= COLS) begin
                        m_x = 0;
                        m_y = (m_y + 1) % ROWS;
                    end else begin
                        m_x = nx;
                    end
                end
                8'h08: begin
                    if (m_x > 0 || m_y > 0) begin
                        if (m_x > 0) m_x = m_x - 1;
                        else begin m_x = COLS - 1; m_y = m_y - 1; end
                        exp_q.push_back({7'h20, 7'(m_x), 5'(m_y), m_col});
                    end
                end
                8'h1B: m_esc = 1'b1;
                default: ;
            endcase
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_raw(input logic [7:0] b);
        rx_data = b;
        rx_received = 1'b1;
        @(posedge clk); #1 rx_received = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b);
    endtask

    task automatic s_send_byte(input logic [7:0] b);
        s_rx_data = b;
        s_rx_received = 1'b1;
        @(posedge clk); #1 s_rx_received = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        int cnt = 0;
        while (busy !== 1'b0 && cnt < 3000) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, cnt);
        end
    endtask

    task automatic send_wait(input logic [7:0] b);
        send_byte(b);
        wait_idle("send");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        got_q.delete(); exp_q.delete(); s_got_q.delete();
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 10))
            0, 1, 2, 3, 4: return 8'($urandom_range(32, 126));
            5:       return 8'h0D;
            6:       return 8'h0A;
            7:       return 8'h09;
            8:       return 8'h08;
            9:       return 8'h1B;
            default: return 8'($urandom_range(127, 255));
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({char_write, char_ascii, char_x, char_y} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_char: got w=%b a=%h x=%0d y=%0d, required all 0", char_write, char_ascii, char_x, char_y);
        end
        n_checks++;
        if (char_color !== 12'hFFF) begin
            n_fail++;
            $display("FAIL reset_color: got %h, required fff", char_color);
        end
        n_checks++;
        if ({cursor_x, cursor_y, fifo_overflow, busy} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_status: got cur=(%0d,%0d) ovf=%b busy=%b, required 0", cursor_x, cursor_y, fifo_overflow, busy);
        end
    endtask

    task automatic test_single_char();
        int cnt = 0;
        got_q.delete(); exp_q.delete();
        model_byte(8'h41);
        rx_data = 8'h41;
        rx_received = 1'b1;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) rx_received = 1'b0;
        end while (char_write !== 1'b1 && cnt < 20);
        n_checks++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL single_latency: char_write after %0d cycles, required 4", cnt);
        end
        n_checks++;
        if ({char_ascii, char_x, char_y, char_color} !== {7'h41, 7'd0, 5'd0, 12'hFFF}) begin
            n_fail++;
            $display("FAIL single_glyph: got a=%h x=%0d y=%0d c=%h, required 41 0 0 fff", char_ascii, char_x, char_y, char_color);
        end
        wait_idle("single");
        n_checks++;
        if ({cursor_x, cursor_y} !== {7'd1, 5'd0}) begin
            n_fail++;
            $display("FAIL single_cursor: got (%0d,%0d), required (1,0)", cursor_x, cursor_y);
        end
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL single_writes: got %0d writes, required 1 matching model", got_q.size());
        end
    endtask

    task automatic test_wrap();
        got_q.delete(); exp_q.delete();
        send_wait(8'h0D);
        for (int i = 0; i < ROWS - 1; i++) send_wait(8'h0A);
        for (int i = 0; i < COLS / TABW; i++) send_wait(8'h09);
        send_wait(8'h61);
        n_checks++;
        if ({cursor_x, cursor_y} !== {7'd105, 5'd29}) begin
            n_fail++;
            $display("FAIL wrap_corner: got (%0d,%0d), required (105,29)", cursor_x, cursor_y);
        end
        send_wait(8'h5A);
        n_checks++;
        if ({cursor_x, cursor_y} !== {7'd0, 5'd0}) begin
            n_fail++;
            $display("FAIL wrap_cursor: got (%0d,%0d), required (0,0)", cursor_x, cursor_y);
        end
        n_checks++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== {7'h5A, 7'd105, 5'd29, 12'hFFF}) begin
            n_fail++;
            $display("FAIL wrap_glyph: got %0d writes, last required Z at (105,29)", got_q.size());
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_color_tab_bs();
        got_q.delete(); exp_q.delete();
        send_wait(8'h1B);
        send_wait(8'h04);
        send_wait(8'h42);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== {7'h42, 7'd0, 5'd0, 12'hF00}) begin
            n_fail++;
            $display("FAIL color_glyph: got %0d writes, required B at (0,0) colour f00", got_q.size());
        end
        send_wait(8'h78);
        send_wait(8'h79);
        send_wait(8'h09);
        n_checks++;
        if (cursor_x !== 7'd8) begin
            n_fail++;
            $display("FAIL tab_x: got %0d, required 8", cursor_x);
        end
        send_wait(8'h0D);
        send_wait(8'h0A);
        send_wait(8'h08);
        n_checks++;
        if ({cursor_x, cursor_y} !== {7'd105, 5'd0}) begin
            n_fail++;
            $display("FAIL bs_cursor: got (%0d,%0d), required (105,0)", cursor_x, cursor_y);
        end
        n_checks++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== {7'h20, 7'd105, 5'd0, 12'hF00}) begin
            n_fail++;
            $display("FAIL bs_glyph: got %0d writes, last required 20 at (105,0)", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ctb_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear_small();
        logic [21:0] e[$];
        int cnt;
        s_got_q.delete();
        e.push_back({7'h51, 2'd0, 1'd0, 12'hFFF});
        e.push_back({7'h52, 2'd1, 1'd0, 12'hFFF});
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                e.push_back({7'h20, 2'(x), 1'(y), 12'hFFF});
        s_send_byte(8'h51);
        s_send_byte(8'h52);
        s_send_byte(8'h0C);
        cnt = 0;
        while (s_busy !== 1'b0 && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_timeout: busy=%b after %0d cycles, required 0", s_busy, cnt);
        end
        n_checks++;
        if (s_got_q.size() != e.size()) begin
            n_fail++;
            $display("FAIL clear_count: got %0d writes, required %0d", s_got_q.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < s_got_q.size(); i++) begin
            n_checks++;
            if (s_got_q[i] !== e[i]) begin
                n_fail++;
                $display("FAIL clear_write[%0d]: got %h, required %h", i, s_got_q[i], e[i]);
            end
        end
        n_checks++;
        if ({s_cursor_x, s_cursor_y} !== 3'd0) begin
            n_fail++;
            $display("FAIL clear_cursor: got (%0d,%0d), required (0,0)", s_cursor_x, s_cursor_y);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b[DEPTH+2];
        do_reset();
        char_busy = 1'b1;
        foreach (b[i]) b[i] = 8'($urandom_range(32, 126));
        // The first byte is already held by the engine, waiting on char_busy,
        // so DEPTH more fit in the FIFO and only the last byte is lost.
        for (int i = 0; i <= DEPTH; i++) model_byte(b[i]);
        foreach (b[i]) send_raw(b[i]);
        n_checks++;
        if (fifo_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b, required 1", fifo_overflow);
        end
        char_busy = 1'b0;
        wait_idle("ovf");
        n_checks++;
        if (fifo_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b, required 1", fifo_overflow);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovf_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int r = 0; r < 25; r++) begin
            int n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) send_byte(rand_byte());
            wait_idle("rand");
            n_checks++;
            if ({cursor_x, cursor_y} !== {7'(m_x), 5'(m_y)}) begin
                n_fail++;
                $display("FAIL rand_cursor[%0d]: got (%0d,%0d), required (%0d,%0d)", r, cursor_x, cursor_y, m_x, m_y);
            end
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_write[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int cnt = 0;
        do_reset();
        auto_done = 1'b0;
        send_raw(8'h43);
        while (char_write !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_checks++;
        if (char_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_write: char_write=%b after %0d cycles, required 1", char_write, cnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({char_write, char_ascii, char_x, char_y, cursor_x, cursor_y, fifo_overflow, busy, char_color}
            !== {34'd0, 12'hFFF}) begin
            n_fail++;
            $display("FAIL rstw_outputs: got w=%b a=%h cur=(%0d,%0d) busy=%b c=%h, required reset values",
                     char_write, char_ascii, cursor_x, cursor_y, busy, char_color);
        end
        rst = 1'b0;
        model_reset();
        stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cursor_x, cursor_y, busy, char_write} !== 14'd0) begin
            n_fail++;
            $display("FAIL rstw_stray: got cur=(%0d,%0d) busy=%b w=%b, required (0,0) 0 0", cursor_x, cursor_y, busy, char_write);
        end
        auto_done = 1'b1;
        got_q.delete(); exp_q.delete();
        send_wait(8'h44);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || {cursor_x, cursor_y} !== {7'(m_x), 5'(m_y)}) begin
            n_fail++;
            $display("FAIL rstw_resume: got %0d writes cur=(%0d,%0d), required 1 write cur=(%0d,%0d)",
                     got_q.size(), cursor_x, cursor_y, m_x, m_y);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx_received = 1'b0; rx_data = 8'h00; char_busy = 1'b0; stray_done = 1'b0;
        s_rx_received = 1'b0; s_rx_data = 8'h00; s_char_busy = 1'b0;
        n_checks = 0;
        n_fail = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_char();
        test_wrap();
        test_color_tab_bs();
        test_clear_small();
        test_overflow();
        test_random();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
